// File: rtl/cipher_pkg.sv
// cipher_pkg: shared LFSR taps, S-box table, controller states and LFSR step helper
package cipher_pkg;

   localparam logic [7:0] TAP1 = 8'h71;
   localparam logic [7:0] TAP2 = 8'h87;
   localparam logic [7:0] TAP3 = 8'h1B;

   localparam logic [2:0] SBOX [8] = '{3'd5, 3'd3, 3'd6, 3'd1, 3'd7, 3'd0, 3'd4, 3'd2};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WARMUP,
      ST_WAIT_IN,
      ST_CRYPT,
      ST_OUT
   } state_e;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] taps);
      return {^(s & taps), s[7:1]};
   endfunction

endpackage

// File: rtl/lfsr3_sbox_keygen.sv
// lfsr3_sbox_keygen: three 8-bit LFSRs combined through a 3-bit S-box into one keystream bit
module lfsr3_sbox_keygen #(
   parameter int SBOX_BIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [23:0] seed,
   output logic        ks
);
   import cipher_pkg::*;

   logic [7:0] s1_q, s2_q, s3_q;
   logic [7:0] s1_d, s2_d, s3_d;
   logic [2:0] sb;

   // load overrides step; with neither the generator position is frozen
   always_comb begin
      s1_d = load ? seed[7:0]   : step ? lfsr_step(s1_q, TAP1) : s1_q;
      s2_d = load ? seed[15:8]  : step ? lfsr_step(s2_q, TAP2) : s2_q;
      s3_d = load ? seed[23:16] : step ? lfsr_step(s3_q, TAP3) : s3_q;
   end

   // all-zero after reset; only a load brings the registers to a usable state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign sb = SBOX[{s1_q[7], s2_q[7], s3_q[7]}];
   assign ks = sb[SBOX_BIT];

endmodule

// File: rtl/cipher_session_ctrl.sv
// cipher_session_ctrl: seeds the keystream generator, runs warm-up and streams bytes through the cipher
module cipher_session_ctrl #(
   parameter int WARMUP   = 64,
   parameter int SBOX_BIT = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [23:0]      key,
   input  logic [23:0]      iv,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             busy,
   output logic             key_err,
   output logic [CNT_W-1:0] byte_count
);
   import cipher_pkg::*;

   localparam logic [15:0] WU_LAST = 16'(WARMUP - 1);

   state_e           state_q, state_d;
   logic [23:0]      key_q, key_d, iv_q, iv_d, seed;
   logic [15:0]      wu_q, wu_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       din_q, din_d, res_q, res_d, out_data_q, out_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stop_pend_q, stop_pend_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic             busy_q, busy_d, key_err_q, key_err_d;
   logic             seed_bad, ks, gen_load, gen_step;

   assign seed     = key_q ^ iv_q;
   assign seed_bad = (seed[7:0] == 8'h00) || (seed[15:8] == 8'h00) || (seed[23:16] == 8'h00);
   assign gen_load = state_q == ST_LOAD;
   assign gen_step = (state_q == ST_WARMUP) || (state_q == ST_CRYPT);

   lfsr3_sbox_keygen #(.SBOX_BIT(SBOX_BIT)) u_keygen (
      .clk  (clk),
      .rst  (rst),
      .load (gen_load),
      .step (gen_step),
      .seed (seed),
      .ks   (ks)
   );

   // session sequencing; outputs are decoded from the next state so they come straight off flops
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      iv_d        = iv_q;
      wu_d        = wu_q;
      bit_d       = bit_q;
      din_d       = din_q;
      res_d       = res_q;
      out_data_d  = out_data_q;
      cnt_d       = cnt_q;
      stop_pend_d = stop_pend_q | (stop & (state_q != ST_IDLE));
      key_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d     = ST_LOAD;
            key_d       = key;
            iv_d        = iv;
            cnt_d       = '0;
            stop_pend_d = 1'b0;
         end
         ST_LOAD: begin
            key_err_d = seed_bad;
            wu_d      = '0;
            state_d   = seed_bad ? ST_IDLE : (WARMUP == 0) ? ST_WAIT_IN : ST_WARMUP;
         end
         ST_WARMUP: begin
            wu_d    = wu_q + 16'd1;
            state_d = (wu_q == WU_LAST) ? ST_WAIT_IN : ST_WARMUP;
         end
         ST_WAIT_IN: if (stop || stop_pend_q) begin
            state_d = ST_IDLE;
         end else if (in_valid) begin
            din_d   = in_data;
            bit_d   = 3'd0;
            state_d = ST_CRYPT;
         end
         ST_CRYPT: begin
            res_d[bit_q] = din_q[bit_q] ^ ks;
            bit_d        = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
               out_data_d = res_d;
               state_d    = ST_OUT;
            end
         end
         ST_OUT: if (out_ready) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_WAIT_IN;
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d  = state_d == ST_WAIT_IN;
      out_valid_d = state_d == ST_OUT;
      busy_d      = state_d != ST_IDLE;
   end

   // controller state; async reset drops any session in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         key_q       <= '0;
         iv_q        <= '0;
         wu_q        <= '0;
         bit_q       <= '0;
         din_q       <= '0;
         res_q       <= '0;
         out_data_q  <= '0;
         cnt_q       <= '0;
         stop_pend_q <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         key_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         iv_q        <= iv_d;
         wu_q        <= wu_d;
         bit_q       <= bit_d;
         din_q       <= din_d;
         res_q       <= res_d;
         out_data_q  <= out_data_d;
         cnt_q       <= cnt_d;
         stop_pend_q <= stop_pend_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         key_err_q   <= key_err_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign busy       = busy_q;
   assign key_err    = key_err_q;
   assign byte_count = cnt_q;

endmodule
